// File: rtl/cube_frame_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cube_frame_loader                                          |
// | Description : Parses framed byte-stream packets and writes each payload  |
// |               into the frame RAM, reporting commit or error per packet.  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module cube_frame_loader #(
    parameter int FRAME_BYTES = 64,
    parameter int MAX_FRAMES  = 151,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        abort,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        wr_en,
    output logic [13:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        frame_done,
    output logic [7:0]  frame_idx_out,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [7:0]  frames_loaded,
    output logic        busy
);

    localparam int            TW           = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0]    c_header     = 8'hA5;
    localparam logic [8:0]    c_max_frames = 9'(MAX_FRAMES);
    localparam logic [5:0]    c_last_byte  = 6'(FRAME_BYTES - 1);
    localparam logic [TW-1:0] c_tmo_last   = TW'(TIMEOUT_CYC - 1);
    localparam logic [1:0]    c_err_sum    = 2'b01;
    localparam logic [1:0]    c_err_idx    = 2'b10;
    localparam logic [1:0]    c_err_tmo    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GET_IDX  = 3'd1,
        S_GET_DATA = 3'd2,
        S_GET_SUM  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_live;
    logic [7:0]    r_idx;
    logic [7:0]    r_sum;
    logic [5:0]    r_cnt;
    logic [TW-1:0] r_tmo;

    logic          w_acc;
    logic          w_in_pkt;
    logic          w_tmo_fire;
    logic          w_done_pulse;
    logic          w_err_pulse;
    logic [1:0]    w_err_code;

    // r_live keeps in_ready low until the first cycle after reset is released
    assign in_ready   = r_live && (r_state != S_DONE);
    assign busy       = (r_state != S_IDLE);
    assign w_acc      = in_valid && in_ready && !abort;
    assign w_in_pkt   = (r_state == S_GET_IDX) || (r_state == S_GET_DATA) ||
                        (r_state == S_GET_SUM);
    assign w_tmo_fire = w_in_pkt && !w_acc && !abort && (r_tmo == c_tmo_last);

    always_comb begin
        w_next       = r_state;
        w_done_pulse = 1'b0;
        w_err_pulse  = 1'b0;
        w_err_code   = 2'b00;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc && (in_data == c_header)) w_next = S_GET_IDX;
                end
                S_GET_IDX: begin
                    if (w_acc) begin
                        if ({1'b0, in_data} >= c_max_frames) begin
                            w_next      = S_IDLE;
                            w_err_pulse = 1'b1;
                            w_err_code  = c_err_idx;
                        end else begin
                            w_next = S_GET_DATA;
                        end
                    end
                end
                S_GET_DATA: begin
                    if (w_acc && (r_cnt == c_last_byte)) w_next = S_GET_SUM;
                end
                S_GET_SUM: begin
                    if (w_acc) begin
                        w_next = S_DONE;
                        if (in_data == r_sum) begin
                            w_done_pulse = 1'b1;
                        end else begin
                            w_err_pulse = 1'b1;
                            w_err_code  = c_err_sum;
                        end
                    end
                end
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
            if (w_tmo_fire) begin
                w_next      = S_IDLE;
                w_err_pulse = 1'b1;
                w_err_code  = c_err_tmo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_live        <= 1'b0;
            r_idx         <= 8'd0;
            r_sum         <= 8'd0;
            r_cnt         <= 6'd0;
            r_tmo         <= '0;
            wr_en         <= 1'b0;
            wr_addr       <= 14'd0;
            wr_data       <= 8'd0;
            frame_done    <= 1'b0;
            frame_idx_out <= 8'd0;
            err           <= 1'b0;
            err_code      <= 2'b00;
            frames_loaded <= 8'd0;
        end else begin
            r_state    <= w_next;
            r_live     <= 1'b1;
            frame_done <= w_done_pulse;
            err        <= w_err_pulse;
            wr_en      <= w_acc && (r_state == S_GET_DATA);

            if (w_err_pulse) err_code <= w_err_code;
            if (w_done_pulse && (frames_loaded != 8'hFF)) frames_loaded <= frames_loaded + 8'd1;
            if (w_acc && (r_state == S_GET_SUM)) frame_idx_out <= r_idx;

            if (abort || !w_in_pkt || w_acc) r_tmo <= '0;
            else                             r_tmo <= r_tmo + TW'(1);

            if (abort) begin
                r_cnt <= 6'd0;
                r_sum <= 8'd0;
            end else if (w_acc && (r_state == S_GET_IDX)) begin
                // Running sum starts at the index byte, which is part of the checksum
                r_idx <= in_data;
                r_sum <= in_data;
                r_cnt <= 6'd0;
            end else if (w_acc && (r_state == S_GET_DATA)) begin
                wr_addr <= {r_idx, r_cnt};
                wr_data <= in_data;
                r_sum   <= r_sum + in_data;
                r_cnt   <= r_cnt + 6'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cube_frame_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cube_frame_loader                                       |
// | Description : Randomized scoreboard bench for cube_frame_loader.         |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_cube_frame_loader;

    localparam int FB   = 64;
    localparam int MAXF = 151;
    localparam int TMO  = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [7:0]  wr_data;
    logic        frame_done;
    logic [7:0]  frame_idx_out;
    logic        err;
    logic [1:0]  err_code;
    logic [7:0]  frames_loaded;
    logic        busy;

    cube_frame_loader #(
        .FRAME_BYTES (FB),
        .MAX_FRAMES  (MAXF),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .abort         (abort),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .frame_done    (frame_done),
        .frame_idx_out (frame_idx_out),
        .err           (err),
        .err_code      (err_code),
        .frames_loaded (frames_loaded),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [13:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct packed {
        logic       is_err;
        logic [1:0] code;
        logic       chk_idx;
        logic [7:0] idx;
        logic [7:0] loaded;
    } ev_t;

    wr_t exp_wr[$];
    ev_t exp_ev[$];
    int  tests = 0;
    int  fails = 0;
    int  model_loaded = 0;
    logic [1:0] model_code = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every write and every pulse must match the next expectation
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_wr.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_write: got addr=%h data=%h expected none", wr_addr, wr_data);
            end else begin
                wr_t w;
                w = exp_wr.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(w.addr));
                check("wr_data", 32'(wr_data), 32'(w.data));
            end
        end
        if ((frame_done === 1'b1) || (err === 1'b1)) begin
            if (exp_ev.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_event: got done=%b err=%b code=%b expected none",
                         frame_done, err, err_code);
            end else begin
                ev_t e;
                e = exp_ev.pop_front();
                check("evt_err", 32'(err), 32'(e.is_err));
                check("evt_done", 32'(frame_done), 32'(!e.is_err));
                if (e.is_err) check("err_code", 32'(err_code), 32'(e.code));
                check("frames_loaded", 32'(frames_loaded), 32'(e.loaded));
                if (e.chk_idx) check("frame_idx_out", 32'(frame_idx_out), 32'(e.idx));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic push_ev(input logic is_err, input logic [1:0] code,
                           input logic chk_idx, input logic [7:0] idx);
        ev_t e;
        if (is_err) model_code = code;
        e.is_err  = is_err;
        e.code    = code;
        e.chk_idx = chk_idx;
        e.idx     = idx;
        e.loaded  = 8'(model_loaded);
        exp_ev.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard;
        guard = 0;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
        if (guard >= 100) begin
            tests++; fails++;
            $display("FAIL in_ready_timeout: got in_ready=0 expected 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // mode: 0 random data, 1 ramp 0..FB-1, 2 all zero; sum_delta corrupts the checksum
    task automatic run_packet(input logic [7:0] idx, input int mode,
                              input logic [7:0] sum_delta, input bit gaps);
        logic [7:0] d [FB];
        int s;
        s = int'(idx);
        for (int i = 0; i < FB; i++) begin
            d[i] = (mode == 1) ? 8'(i) : (mode == 2) ? 8'd0 : 8'($urandom);
            s += int'(d[i]);
        end
        s = s % 256;
        if (int'(idx) >= MAXF) begin
            push_ev(1'b1, 2'b10, 1'b0, 8'd0);
            send_byte(8'hA5, gaps);
            send_byte(idx, gaps);
        end else begin
            for (int i = 0; i < FB; i++)
                exp_wr.push_back('{addr: 14'(int'(idx) * FB + i), data: d[i]});
            if (sum_delta == 8'd0) begin
                if (model_loaded < 255) model_loaded++;
                push_ev(1'b0, 2'b00, 1'b1, idx);
            end else begin
                push_ev(1'b1, 2'b01, 1'b1, idx);
            end
            send_byte(8'hA5, gaps);
            send_byte(idx, gaps);
            for (int i = 0; i < FB; i++) send_byte(d[i], gaps);
            send_byte(8'(s) + sum_delta, gaps);
        end
    endtask

    task automatic send_partial(input logic [7:0] idx, input int n);
        logic [7:0] b;
        send_byte(8'hA5, 1'b0);
        send_byte(idx, 1'b0);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            exp_wr.push_back('{addr: 14'(int'(idx) * FB + i), data: b});
            send_byte(b, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        // Reset values
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_pulses", 32'({frame_done, err}), 0);
        check("rst_err_code", 32'(err_code), 0);
        check("rst_frame_idx", 32'(frame_idx_out), 0);
        check("rst_loaded", 32'(frames_loaded), 0);
        check("rst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed: good ramp, corrupted sum, bad index, max index, junk prefix
        run_packet(8'h03, 1, 8'd0, 1'b0);
        idle(2);
        check("t1_loaded", 32'(frames_loaded), 1);
        check("t1_idx", 32'(frame_idx_out), 32'h03);
        run_packet(8'h03, 1, 8'd1, 1'b0);
        idle(2);
        check("t2_loaded", 32'(frames_loaded), 1);
        check("t2_code", 32'(err_code), 1);
        run_packet(8'h97, 2, 8'd0, 1'b0);
        run_packet(8'h96, 2, 8'd0, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h5A, 1'b0);
        run_packet(8'h00, 0, 8'd0, 1'b0);

        // Timeout after 10 data bytes, then recovery
        send_partial(8'h05, 10);
        push_ev(1'b1, 2'b11, 1'b0, 8'd0);
        idle(TMO + 10);
        check("tmo_busy", 32'(busy), 0);
        run_packet(8'h05, 0, 8'd0, 1'b0);

        // Abort after 30 data bytes while a byte is offered in the same cycle
        send_partial(8'h10, 30);
        in_valid = 1'b1; in_data = 8'h55; abort = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 0);
        check("abort_wr_en", 32'(wr_en), 0);
        check("abort_loaded", 32'(frames_loaded), 32'(model_loaded));
        check("abort_code", 32'(err_code), 32'(model_code));
        @(posedge clk); #1;
        run_packet(8'h10, 0, 8'd0, 1'b1);

        // Reset mid-packet clears the counters
        send_partial(8'h20, 30);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_loaded = 0;
        model_code = 2'b00;
        @(negedge clk);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_wr_en", 32'(wr_en), 0);
        check("mrst_loaded", 32'(frames_loaded), 0);
        @(posedge clk); #1;

        // Randomized packets, mixing gaps and back-to-back traffic
        for (int n = 0; n < 16; n++) begin
            logic [7:0] idx;
            logic [7:0] dlt;
            idx = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(151, 255))
                                              : 8'($urandom_range(0, 150));
            dlt = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            run_packet(idx, 0, dlt, 1'($urandom_range(0, 1)));
        end

        // Drive the commit count through saturation
        while (model_loaded < 255) run_packet(8'($urandom_range(0, 150)), 0, 8'd0, 1'b0);
        for (int n = 0; n < 3; n++) run_packet(8'($urandom_range(0, 150)), 0, 8'd0, 1'b0);
        idle(4);
        check("sat_loaded", 32'(frames_loaded), 255);

        idle(10);
        check("writes_drained", 32'(exp_wr.size()), 0);
        check("events_drained", 32'(exp_ev.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
